// File: rtl/adder_pipe_nbit_if.sv
// Operand/result handshake bundle for adder_pipe_nbit; master drives operands and out_ready.
interface adder_pipe_nbit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             Overflow;
  logic             Zero;

  modport master (
    output in_valid, A, B, C0, SUB, out_ready,
    input  in_ready, out_valid, SUM, COUT, Overflow, Zero
  );

  modport slave (
    input  in_valid, A, B, C0, SUB, out_ready,
    output in_ready, out_valid, SUM, COUT, Overflow, Zero
  );
endinterface

// File: rtl/adder_pipe_nbit.sv
// Pipelined add/sub, CHUNK bits of carry chain per stage; ADDER_SAT_EN makes SUM saturate on overflow.
// Latency STAGES cycles; a stage loads when downstream is empty or advancing, so in_ready drops only when full and stalled.
module adder_pipe_nbit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic             clk,
  input logic             rst_n,
  adder_pipe_nbit_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];

  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [STAGES-1:0] take;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];
  logic [CHUNK:0]    part  [STAGES];
  logic [WIDTH-1:0]  raw;
  logic              c_msb;

  // Stage k may load if out_ready is high or any stage from k to the end is empty.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      take[k] = bus.out_ready | ~(&(vld_q | STAGES'((64'd1 << k) - 64'd1)));
    end
  end

  always_comb begin
    src_v[0] = bus.in_valid & take[0];
    src_a[0] = bus.A;
    src_b[0] = bus.SUB ? ~bus.B : bus.B;
    src_c[0] = bus.SUB ^ bus.C0;
    src_r[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = vld_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = cy_q[k-1];
      src_r[k] = res_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, src_a[k][k*CHUNK +: CHUNK]} + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, src_c[k]};
      res_d[k] = src_r[k];
      res_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
    end
    raw    = res_d[LAST];
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    c_msb  = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ raw[WIDTH-1];
    cout_d = part[LAST][CHUNK];
    ovf_d  = c_msb ^ cout_d;
`ifdef ADDER_SAT_EN
    sum_d  = ovf_d ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
`else
    sum_d  = raw;
`endif
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (take[k]) vld_q[k] <= src_v[k];
      end
      if (take[LAST] && src_v[LAST]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (take[k]) begin
        a_q[k]   <= src_a[k];
        b_q[k]   <= src_b[k];
        cy_q[k]  <= part[k][CHUNK];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign bus.in_ready  = take[0];
  assign bus.out_valid = vld_q[LAST];
  assign bus.SUM       = sum_q;
  assign bus.COUT      = cout_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: directed vector table, back-pressure and reset sequences, random scoreboard on three geometries.
module tb_adder_pipe_nbit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  adder_pipe_nbit_if #(.WIDTH(8))  ba ();
  adder_pipe_nbit_if #(.WIDTH(8))  bb ();
  adder_pipe_nbit_if #(.WIDTH(32)) bc ();

  adder_pipe_nbit #(.WIDTH(8),  .CHUNK(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  adder_pipe_nbit #(.WIDTH(8),  .CHUNK(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
  adder_pipe_nbit #(.WIDTH(32), .CHUNK(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bc));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c0;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  exp_t exp_q [3][$];
  logic held [3];
  exp_t prev [3];
  vec_t tbl [7];

  // Reference: plain integer arithmetic plus the signed-overflow sign rule.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c0, input logic sub);
    longint unsigned mask, av, bv, full;
    logic sa, sb, ss;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    av = 64'(a) & mask;
    bv = 64'(b) & mask;
    if (sub) bv = ~bv & mask;
    full = av + bv + ((sub ? !c0 : c0) ? 64'd1 : 64'd0);
    e.sum  = 32'(full & mask);
    e.cout = ((full >> w) & 64'd1) != 0;
    sa = ((av >> (w - 1)) & 64'd1) != 0;
    sb = ((bv >> (w - 1)) & 64'd1) != 0;
    ss = e.sum[w-1];
    e.ovf = (sa == sb) && (ss != sa);
`ifdef ADDER_SAT_EN
    if (e.ovf) e.sum = sa ? 32'(64'd1 << (w - 1)) : 32'(mask >> 1);
`endif
    e.zero = (e.sum == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic observe(input int id, input logic iv, input logic ir, input logic ov,
                         input logic ordy, input exp_t act, input exp_t mdl);
    exp_t e;
    if (held[id]) begin
      checks++;
      if (!ov || act !== prev[id]) begin
        failures++;
        $display("FAIL hold%0d: got vld=%b out=0x%0h, required vld=1 out=0x%0h", id, ov, act, prev[id]);
      end
    end
    if (ov && ordy) begin
      checks++;
      if (exp_q[id].size() == 0) begin
        failures++;
        $display("FAIL sb%0d: unexpected result 0x%0h, required none", id, act);
      end else begin
        e = exp_q[id].pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL sb%0d: got sum=%h c=%b v=%b z=%b, required sum=%h c=%b v=%b z=%b",
                   id, act.sum, act.cout, act.ovf, act.zero, e.sum, e.cout, e.ovf, e.zero);
        end
      end
    end
    if (iv && ir) exp_q[id].push_back(mdl);
    held[id] = ov && !ordy;
    prev[id] = act;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_q[i].delete();
        held[i] = 1'b0;
      end
    end else begin
      observe(0, ba.in_valid, ba.in_ready, ba.out_valid, ba.out_ready,
              {32'(ba.SUM), ba.COUT, ba.Overflow, ba.Zero},
              model(8, 32'(ba.A), 32'(ba.B), ba.C0, ba.SUB));
      observe(1, bb.in_valid, bb.in_ready, bb.out_valid, bb.out_ready,
              {32'(bb.SUM), bb.COUT, bb.Overflow, bb.Zero},
              model(8, 32'(bb.A), 32'(bb.B), bb.C0, bb.SUB));
      observe(2, bc.in_valid, bc.in_ready, bc.out_valid, bc.out_ready,
              {bc.SUM, bc.COUT, bc.Overflow, bc.Zero},
              model(32, bc.A, bc.B, bc.C0, bc.SUB));
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, " out_valid"}, ba.out_valid, 0);
    chk({tag, " SUM"},       ba.SUM, 0);
    chk({tag, " COUT"},      ba.COUT, 0);
    chk({tag, " Overflow"},  ba.Overflow, 0);
    chk({tag, " Zero"},      ba.Zero, 0);
    chk({tag, " in_ready"},  ba.in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    @(posedge clk); #1;
    ba.A = v.a; ba.B = v.b; ba.C0 = v.c0; ba.SUB = v.sub;
    ba.in_valid = 1'b1; ba.out_ready = 1'b1;
    cyc = 0;
    while (!ba.in_ready && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    ba.in_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!ba.out_valid && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, " latency"},  cyc, 2);
    chk({tag, " SUM"},      ba.SUM, v.sum);
    chk({tag, " COUT"},     ba.COUT, v.cout);
    chk({tag, " Overflow"}, ba.Overflow, v.ovf);
    chk({tag, " Zero"},     ba.Zero, v.zero);
  endtask

  task automatic drive_a(input logic [7:0] a, input logic [7:0] b, input logic c0, input logic sub);
    ba.A = a; ba.B = b; ba.C0 = c0; ba.SUB = sub;
  endtask

  initial begin
    logic [7:0] opa [4];
    logic [7:0] opb [4];
    logic       opc [4];
    logic       ops [4];
    logic       ir_log [4];
    exp_t       first0, first1;
    int         nacc, nout, cyc;
    int         acc [3];

    ba.in_valid = 0; ba.out_ready = 0; ba.A = 0; ba.B = 0; ba.C0 = 0; ba.SUB = 0;
    bb.in_valid = 0; bb.out_ready = 0; bb.A = 0; bb.B = 0; bb.C0 = 0; bb.SUB = 0;
    bc.in_valid = 0; bc.out_ready = 0; bc.A = 0; bc.B = 0; bc.C0 = 0; bc.SUB = 0;

    tbl[0] = '{8'h93, 8'h2B, 1'b1, 1'b0, 8'hBF, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hDD, 8'hA4, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
`ifdef ADDER_SAT_EN
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
`else
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
`endif
    tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure: four ops offered while the consumer stalls for four cycles.
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'($urandom); opb[i] = 8'($urandom);
      opc[i] = 1'($urandom); ops[i] = 1'($urandom);
    end
    @(posedge clk); #1;
    ba.out_ready = 1'b0; ba.in_valid = 1'b1;
    nacc = 0;
    drive_a(opa[0], opb[0], opc[0], ops[0]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ir_log[c] = ba.in_ready;
      if (ba.in_ready) nacc++;
      if (c == 2) first0 = {32'(ba.SUM), ba.COUT, ba.Overflow, ba.Zero};
      if (c == 3) first1 = {32'(ba.SUM), ba.COUT, ba.Overflow, ba.Zero};
      @(posedge clk); #1;
      drive_a(opa[nacc], opb[nacc], opc[nacc], ops[nacc]);
    end
    chk("bp accepts while stalled", nacc, 2);
    chk("bp in_ready when full", ir_log[2], 0);
    chk("bp first result", first0, model(8, 32'(opa[0]), 32'(opb[0]), opc[0], ops[0]));
    chk("bp first result held", first1, first0);
    ba.out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 40 && nout < 4; c++) begin
      @(negedge clk);
      if (ba.out_valid) begin
        chk($sformatf("bp out%0d", nout), {32'(ba.SUM), ba.COUT, ba.Overflow, ba.Zero},
            model(8, 32'(opa[nout]), 32'(opb[nout]), opc[nout], ops[nout]));
        nout++;
      end
      if (ba.in_valid && ba.in_ready) nacc++;
      @(posedge clk); #1;
      if (nacc >= 4) ba.in_valid = 1'b0;
      else drive_a(opa[nacc], opb[nacc], opc[nacc], ops[nacc]);
    end
    chk("bp results delivered", nout, 4);

    // Reset with two ops in flight and a third offered during reset.
    @(posedge clk); #1;
    ba.out_ready = 1'b0; ba.in_valid = 1'b1;
    drive_a(8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_a(8'h33, 8'h44, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_a(8'h55, 8'h66, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; ba.in_valid = 1'b0; ba.out_ready = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    run_vec(tbl[0], "post-reset");

    // Random streaming on all three geometries at once.
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk); #1;
      ba.in_valid = (acc[0] < 1000) && ($urandom_range(0, 9) < 7);
      ba.A = 8'($urandom); ba.B = 8'($urandom); ba.C0 = 1'($urandom); ba.SUB = 1'($urandom);
      ba.out_ready = (acc[0] >= 1000) || ($urandom_range(0, 3) != 0);
      bb.in_valid = (acc[1] < 1000) && ($urandom_range(0, 9) < 7);
      bb.A = 8'($urandom); bb.B = 8'($urandom); bb.C0 = 1'($urandom); bb.SUB = 1'($urandom);
      bb.out_ready = (acc[1] >= 1000) || ($urandom_range(0, 3) != 0);
      bc.in_valid = (acc[2] < 1000) && ($urandom_range(0, 9) < 7);
      bc.A = $urandom; bc.B = $urandom; bc.C0 = 1'($urandom); bc.SUB = 1'($urandom);
      bc.out_ready = (acc[2] >= 1000) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ba.in_valid && ba.in_ready) acc[0]++;
      if (bb.in_valid && bb.in_ready) acc[1]++;
      if (bc.in_valid && bc.in_ready) acc[2]++;
      if (acc[0] >= 1000 && acc[1] >= 1000 && acc[2] >= 1000 &&
          exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
    end
    @(posedge clk); #1;
    ba.in_valid = 0; bb.in_valid = 0; bc.in_valid = 0;
    @(negedge clk);
    chk("rand accepted a", acc[0], 1000);
    chk("rand accepted b", acc[1], 1000);
    chk("rand accepted c", acc[2], 1000);
    chk("rand drained a", exp_q[0].size(), 0);
    chk("rand drained b", exp_q[1].size(), 0);
    chk("rand drained c", exp_q[2].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_pipe_nbit.md
# adder_pipe_nbit

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. It generalises the fixed 8-bit combinational adder to any `WIDTH`. The carry chain is split into `CHUNK`-bit stages, so wide adds close timing in the CPU datapath. It also adds subtract mode, carry-out and zero flags, back-pressure, and optional saturation. It sits between the ALU operand latches and the writeback register.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Must be a multiple of `CHUNK`.
- `CHUNK`, 8: bits added per pipeline stage. `STAGES = WIDTH/CHUNK`, with `STAGES >= 1`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: operands `A`, `B`, `C0`, `SUB` are valid.
- `in_ready`, out, 1: the block accepts operands this cycle.
- `A`, in, `WIDTH`: operand A.
- `B`, in, `WIDTH`: operand B.
- `C0`, in, 1: carry-in when `SUB=0`, borrow-in when `SUB=1`.
- `SUB`, in, 1: 0 computes A+B+C0; 1 computes A−B−C0.
- `out_valid`, out, 1: result outputs are valid.
- `out_ready`, in, 1: the consumer takes the result this cycle.
- `SUM`, out, `WIDTH`: result.
- `COUT`, out, 1: raw carry out of the MSB. With `SUB=1`, 1 means no borrow.
- `Overflow`, out, 1: signed overflow.
- `Zero`, out, 1: `SUM == 0`, evaluated after saturation.

## Operation
- Effective operation: `B' = SUB ? ~B : B` and `cin = SUB ? ~C0 : C0`. Result = A + B' + cin, modulo 2^WIDTH.
- Stage k (0..`STAGES`−1) holds:
  - a valid bit;
  - the accumulated low result bits [(k+1)·CHUNK−1:0];
  - the carry out of chunk k;
  - the unconsumed high slices of A and B'.
- Stage 0 loads on accept and adds chunk 0 with `cin`. Stage k adds chunk k with the carry from stage k−1.
- The final stage also computes:
  - `COUT` = carry out of bit WIDTH−1;
  - `Overflow` = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1;
  - `Zero`.
- Advance rule: stage k loads when stage k+1 is empty or is advancing. The last stage is advancing when `out_valid & out_ready`.
- `in_ready` = stage 0 empty OR stage 0 advancing. Accept = `in_valid & in_ready`.
- A bubble (an empty stage) collapses when the downstream stage is stalled. The pipeline holds up to `STAGES` results.
- Outputs are driven directly from final-stage registers.
- While `out_valid=1 & out_ready=0`, `SUM`, `COUT`, `Overflow` and `Zero` stay stable.
- Input values are don't-care while `in_valid=0`.

## Timing
- Reset (`rst_n` low at a rising edge) clears all stage valid bits.
  - Next cycle: `out_valid=0`, `SUM=0`, `COUT=0`, `Overflow=0`, `Zero=0`, `in_ready=1`.
  - Operations in flight are discarded with no partial output.
  - An input presented in the same cycle as reset is not accepted.
- Latency: for an input accepted at edge E, `out_valid` is high in the cycle after edge E+STAGES−1 when no stall occurs. That is `STAGES` cycles from the accepting cycle to the output cycle. With `STAGES=1`, the result is visible the cycle after accept.
- Throughput: one operation per cycle while `out_ready=1`.
- Simultaneous accept and output in the same cycle is legal when the pipeline is full and `out_ready=1`. `in_ready` stays 1.
- Full pipeline with `out_ready=0`: `in_ready=0` in that same cycle, combinationally.
- Results emerge in acceptance order. None are lost or duplicated.

## Configuration
- `ADDER_SAT_EN` defined:
  - On `Overflow=1`, `SUM` saturates to 0111…1 if the true result is positive, and to 1000…0 if it is negative. The true sign is the complement of the raw MSB.
  - `Overflow` and `COUT` still report raw values.
  - `Zero` reflects the saturated `SUM`.
- `ADDER_SAT_EN` undefined: `SUM` is always the raw modulo result. No saturation logic is synthesised.

## Test plan
All cases use WIDTH=8, CHUNK=4, STAGES=2, `out_ready=1` unless noted.
- A=0x93, B=0x2B, C0=1, SUB=0 -> SUM=0xBF, COUT=0, Overflow=0, Zero=0, two cycles after accept. Then A=0xDD, B=0xA4, C0=0 -> SUM=0x81, COUT=1, Overflow=0.
- A=0x7F, B=0x01, C0=0, SUB=0 -> Overflow=1, COUT=0. SUM=0x80 without `ADDER_SAT_EN`, 0x7F with it. Also A=0x80, B=0xFF -> SUM=0x7F raw or 0x80 saturated, Overflow=1, COUT=1.
- SUB=1: A=0x05, B=0x07, C0=0 -> SUM=0xFE, COUT=0. Then A=0x07, B=0x07, C0=0 -> SUM=0x00, Zero=1, COUT=1. Then A=0x07, B=0x05, C0=1 -> SUM=0x01.
- Back-pressure: stream 4 ops with `in_valid=1` continuously while `out_ready=0` for 4 cycles.
  - `in_ready` drops after 2 accepts.
  - The first result is held stable.
  - After `out_ready` is released, all 4 results emerge in order with no loss.
- Reset mid-operation: assert `rst_n=0` with 2 ops in flight -> next cycle `out_valid=0` and all outputs 0. After release, a new op completes normally with 2-cycle latency.
- Random streaming: 1000 random ops with random `in_valid`/`out_ready`, checked against a scoreboard model, for CHUNK=8 and CHUNK=4.
